// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default bit period.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 217;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_nibble_src_if.sv
// Receive-side signal bundle: serial line in, byte/nibble/status results out.
interface uart_rx_nibble_src_if;

    logic       rx_serial;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [3:0] upper_nibble;
    logic [3:0] lower_nibble;
    logic       frame_err;

    modport master (
        output rx_serial,
        input  rx_dv, rx_byte, upper_nibble, lower_nibble, frame_err
    );

    modport slave (
        input  rx_serial,
        output rx_dv, rx_byte, upper_nibble, lower_nibble, frame_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/uart_rx_nibble_src.sv
// 8N1 UART receiver presenting the last byte and its two nibbles for seven-segment decoders.
// Optional stop-bit checking is enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx_nibble_src
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic [3:0] o_Upper_Nibble,
    output logic [3:0] o_Lower_Nibble,
    output logic       o_Frame_Err
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_e     r_state;
    rx_state_e     w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_dv;
    logic          w_rx;
    logic          w_cnt_last;
    logic          w_cnt_half;
    logic          w_bit_sample;
    logic          w_stop_sample;
    logic          w_accept;
    logic          w_ferr;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_D     (i_Rx_Serial),
        .o_Q     (w_rx)
    );

    assign w_cnt_last = (r_cnt == LAST);
    assign w_cnt_half = (r_cnt == HALF);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (!w_rx) w_next = S_START;
            S_START:   if (w_cnt_half) w_next = w_rx ? S_IDLE : S_DATA;
            S_DATA:    if (w_cnt_last && r_idx == 3'd7) w_next = S_STOP;
            S_STOP:    if (w_cnt_last) w_next = S_CLEANUP;
            // A low line here is already the next start bit.
            S_CLEANUP: w_next = w_rx ? S_IDLE : S_START;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_bit_sample  = (r_state == S_DATA) && w_cnt_last;
        w_stop_sample = (r_state == S_STOP) && w_cnt_last;
`ifdef UART_RX_FRAME_ERR_EN
        w_accept      = w_stop_sample && w_rx;
        w_ferr        = w_stop_sample && !w_rx;
`else
        w_accept      = w_stop_sample;
        w_ferr        = 1'b0;
`endif
    end

    // Counter restarts on every state change and after each data bit, so it never wraps.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (r_state == S_IDLE || r_state == S_CLEANUP || w_next != r_state || w_bit_sample)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_state != S_DATA)
                r_idx <= 3'd0;
            else if (w_bit_sample)
                r_idx <= r_idx + 3'd1;

            if (w_bit_sample)
                r_shift[r_idx] <= w_rx;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_dv   <= 1'b0;
            r_byte <= 8'h00;
        end else begin
            r_dv <= w_accept;
            if (w_accept)
                r_byte <= r_shift;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic r_ferr;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_ferr <= 1'b0;
        else          r_ferr <= w_ferr;
    end

    assign o_Frame_Err = r_ferr;
`else
    assign o_Frame_Err = w_ferr;
`endif

    assign o_Rx_DV        = r_dv;
    assign o_Rx_Byte      = r_byte;
    assign o_Upper_Nibble = r_byte[7:4];
    assign o_Lower_Nibble = r_byte[3:0];

endmodule

// File: tb/tb_uart_rx_nibble_src.sv
// Randomized bench for uart_rx_nibble_src with a frame-level expectation queue and directed cases.
module tb_uart_rx_nibble_src;

    localparam int C    = 8;
    localparam int HALF = (C - 1) / 2;
    // Line falls after edge T; the stop sample lands at 2 sync + 1 detect + 1 + half bit + 9 bit periods.
    localparam int LAT  = 4 + HALF + 9 * C;

    typedef struct {
        int         t;
        logic [7:0] d;
        bit         err;
    } ev_t;

    logic i_Clk;
    logic i_Rst_L;
    int   cyc;
    int   total;
    int   bad;
    int   dv_cnt;
    int   fe_cnt;
    int   dv_times[$];
    ev_t  exp_q[$];
    logic [7:0] exp_byte;
    logic       e_dv;
    logic       e_fe;

    uart_rx_nibble_src_if bus();

    uart_rx_nibble_src #(.CLKS_PER_BIT(C)) dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Rx_Serial    (bus.rx_serial),
        .o_Rx_DV        (bus.rx_dv),
        .o_Rx_Byte      (bus.rx_byte),
        .o_Upper_Nibble (bus.upper_nibble),
        .o_Lower_Nibble (bus.lower_nibble),
        .o_Frame_Err    (bus.frame_err)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the frame-level model.
    always @(negedge i_Clk) begin
        e_dv = 1'b0;
        e_fe = 1'b0;
        if (!i_Rst_L) begin
            exp_q.delete();
            exp_byte = 8'h00;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
                if (exp_q[0].t == cyc) begin
                    if (exp_q[0].err) e_fe = 1'b1;
                    else begin
                        e_dv     = 1'b1;
                        exp_byte = exp_q[0].d;
                    end
                end
                void'(exp_q.pop_front());
            end
        end
        chk("dv",    32'(bus.rx_dv),        32'(e_dv));
        chk("ferr",  32'(bus.frame_err),    32'(e_fe));
        chk("byte",  32'(bus.rx_byte),      32'(exp_byte));
        chk("upper", 32'(bus.upper_nibble), 32'(exp_byte[7:4]));
        chk("lower", 32'(bus.lower_nibble), 32'(exp_byte[3:0]));
        if (bus.rx_dv === 1'b1) begin
            dv_cnt++;
            dv_times.push_back(cyc);
        end
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic drive_bits(input logic [7:0] d, input bit stop, input int nbits);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.rx_serial = fr[i];
            repeat (C) @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit stop);
        ev_t e;
        e.t = cyc + LAT;
        e.d = d;
`ifdef UART_RX_FRAME_ERR_EN
        e.err = !stop;
`else
        e.err = 1'b0;
`endif
        exp_q.push_back(e);
        drive_bits(d, stop, 10);
    endtask

    task automatic idle(input int n);
        bus.rx_serial = 1'b1;
        repeat (n) @(posedge i_Clk);
        if (n > 0) #1;
    endtask

    initial begin
        int         n0;
        int         f0;
        int         t0;
        logic [7:0] d;
        bit         stop;
        total = 0;
        bad   = 0;
        dv_cnt = 0;
        fe_cnt = 0;
        exp_byte = 8'h00;
        bus.rx_serial = 1'b1;
        i_Rst_L = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1;
        chk("rst_dv",   32'(bus.rx_dv),        32'h0);
        chk("rst_byte", 32'(bus.rx_byte),      32'h00);
        chk("rst_nib",  32'({bus.upper_nibble, bus.lower_nibble}), 32'h00);
        chk("rst_fe",   32'(bus.frame_err),    32'h0);
        i_Rst_L = 1'b1;
        idle(5);

        // 0xA5 single frame
        n0 = dv_cnt;
        send(8'hA5, 1'b1);
        idle(20);
        chk("a5_dvcnt", 32'(dv_cnt - n0), 32'd1);
        chk("a5_byte",  32'(bus.rx_byte), 32'hA5);
        chk("a5_upper", 32'(bus.upper_nibble), 32'hA);
        chk("a5_lower", 32'(bus.lower_nibble), 32'h5);

        // Short low glitch on an idle line is rejected; a following frame still receives.
        n0 = dv_cnt;
        bus.rx_serial = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        idle(20);
        chk("glitch_dvcnt", 32'(dv_cnt - n0), 32'd0);
        chk("glitch_byte",  32'(bus.rx_byte), 32'hA5);
        send(8'h3E, 1'b1);
        idle(10);
        chk("post_glitch_byte", 32'(bus.rx_byte), 32'h3E);

        // Back-to-back 0x00, 0xFF
        n0 = dv_cnt;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(20);
        chk("b2b_dvcnt", 32'(dv_cnt - n0), 32'd2);
        if (dv_cnt - n0 == 2)
            chk("b2b_gap", 32'(dv_times[n0 + 1] - dv_times[n0]), 32'd80);
        chk("b2b_byte", 32'(bus.rx_byte), 32'hFF);
        chk("b2b_nib",  32'({bus.upper_nibble, bus.lower_nibble}), 32'hFF);

        // Bad stop bit after 0x12
        send(8'h12, 1'b1);
        idle(5);
        n0 = dv_cnt;
        f0 = fe_cnt;
        send(8'h3C, 1'b0);
        idle(25);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_cnt",   32'(fe_cnt - f0),   32'd1);
        chk("ferr_dvcnt", 32'(dv_cnt - n0),   32'd0);
        chk("ferr_byte",  32'(bus.rx_byte),   32'h12);
`else
        chk("ferr_cnt",   32'(fe_cnt - f0),   32'd0);
        chk("ferr_dvcnt", 32'(dv_cnt - n0),   32'd1);
        chk("ferr_byte",  32'(bus.rx_byte),   32'h3C);
`endif

        // Randomized frames with random gaps; bad stops get a recovery gap.
        for (int k = 0; k < 40; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send(d, stop);
            if (!stop) idle(20 + $urandom_range(0, 5));
            else       idle($urandom_range(0, 4));
        end
        idle(20);

        // Reset during data bit 4 of 0x77
        send(8'h5A, 1'b1);
        idle(10);
        n0 = dv_cnt;
        drive_bits(8'h77, 1'b1, 5);
        bus.rx_serial = 1'b1;
        repeat (3) @(posedge i_Clk);
        #3;
        i_Rst_L = 1'b0;
        #1;
        chk("midrst_dv",   32'(bus.rx_dv),   32'h0);
        chk("midrst_byte", 32'(bus.rx_byte), 32'h00);
        chk("midrst_nib",  32'({bus.upper_nibble, bus.lower_nibble}), 32'h00);
        chk("midrst_fe",   32'(bus.frame_err), 32'h0);
        repeat (3) @(posedge i_Clk);
        #1;
        i_Rst_L = 1'b1;
        idle(30);
        chk("midrst_nodv", 32'(dv_cnt - n0), 32'd0);
        t0 = dv_cnt;
        send(8'h81, 1'b1);
        idle(20);
        chk("r81_dvcnt", 32'(dv_cnt - t0), 32'd1);
        chk("r81_byte",  32'(bus.rx_byte), 32'h81);
        chk("r81_upper", 32'(bus.upper_nibble), 32'h8);
        chk("r81_lower", 32'(bus.lower_nibble), 32'h1);

        chk("pending_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_nibble_src.md
UART_RX_NIBBLE_SRC -- requirements
Module: uart_rx_nibble_src

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 217, i_Clk cycles per serial bit (115200 baud at 25 MHz); legal range >= 4.
REQ-002 SHALL have port: i_Clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port: i_Rst_L  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: i_Rx_Serial  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 SHALL have port: o_Rx_DV  output  1  one-cycle pulse when a byte is accepted.
REQ-006 SHALL have port: o_Rx_Byte  output  8  last accepted byte, held.
REQ-007 SHALL have port: o_Upper_Nibble  output  4  o_Rx_Byte[7:4], held; drives a downstream 4-bit-to-seven-segment decoder.
REQ-008 SHALL have port: o_Lower_Nibble  output  4  o_Rx_Byte[3:0], held; drives a second decoder.
REQ-009 SHALL have port: o_Frame_Err  output  1  one-cycle pulse on a bad stop bit (see Configuration).

Function
REQ-010 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, CLEANUP.
REQ-012 IDLE: counter and bit index held at 0; a synchronized 0 moves the FSM to START.
REQ-013 START: count to (CLKS_PER_BIT-1)/2; at that count, line 0 -> DATA with counter cleared; line 1 -> IDLE (glitch rejected, no output change).
REQ-014 DATA: count to CLKS_PER_BIT-1, then sample into bit[index], index 0..7 LSB first; after index 7 -> STOP.
REQ-015 STOP: count to CLKS_PER_BIT-1, then sample the stop bit -> CLEANUP.
REQ-016 In the cycle of the stop-bit sample, the accept decision registers: o_Rx_DV=1 for exactly one cycle, and o_Rx_Byte and both nibbles update in that same cycle.
REQ-017 CLEANUP SHALL last exactly one cycle, drive o_Rx_DV=0, then return to IDLE.
REQ-018 A line low during CLEANUP or IDLE SHALL start the next frame, so back-to-back frames need no extra idle bits.
REQ-019 Counter width SHALL be $clog2(CLKS_PER_BIT); the counter never wraps within a state.
REQ-020 Nibble outputs SHALL always equal the corresponding halves of o_Rx_Byte, with no extra latency.

Reset
REQ-021 When i_Rst_L=0: FSM->IDLE; counter and index->0; synchronizer flops->1; o_Rx_DV=0; o_Rx_Byte=8'h00; nibbles=4'h0; o_Frame_Err=0.
REQ-022 Reset mid-frame SHALL discard the partial byte with no DV pulse; the first falling edge after release starts a fresh frame.

Configuration
REQ-023 Macro UART_RX_FRAME_ERR_EN defined: a stop sample of 0 pulses o_Frame_Err for one cycle, suppresses o_Rx_DV, and leaves o_Rx_Byte and the nibbles unchanged.
REQ-024 Macro UART_RX_FRAME_ERR_EN undefined: o_Frame_Err is tied to 0, and every completed frame is accepted regardless of the stop-bit value.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state encoding and the default CLKS_PER_BIT constant.
REQ-026 The synchronizer SHALL be sub-module sync_2ff (async active-low reset, reset value parameterized, here 1); no other sub-modules.

Verification (CLKS_PER_BIT=8)
REQ-027 Send 0xA5 -> exactly one o_Rx_DV pulse; o_Rx_Byte=0xA5; upper=0xA; lower=0x5; values held afterward.
REQ-028 Drive a 2-cycle low glitch on an idle line -> no DV; outputs unchanged; FSM back in IDLE.
REQ-029 Send 0x00 then 0xFF back-to-back -> two DV pulses, 80 cycles apart from frame start; final byte 0xFF, nibbles F/F.
REQ-030 With the macro defined, send 0x3C with stop=0 after prior byte 0x12 -> o_Frame_Err pulses; no DV; byte stays 0x12. With the macro undefined -> DV pulses and byte=0x3C.
REQ-031 Assert i_Rst_L low during data bit 4 of 0x77 -> all outputs 0 immediately; after release, send 0x81 -> byte=0x81, nibbles 8/1.
